// File: rtl/delay_sink_fifo_pkg.sv
// delay_sink_fifo_pkg: shared clog2 helper for the delay sink FIFO
package delay_sink_fifo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sink_fifo_mem.sv
// sink_fifo_mem: DEPTH x DATA_WIDTH storage, sync write port, async read port, no reset
//   clk            rising-edge clock
//   we/waddr/wdata write port, captured at the rising edge
//   raddr/rdata    combinational read port
module sink_fifo_mem
    import delay_sink_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/delay_sink_fifo.sv
// delay_sink_fifo: FWFT sink FIFO for a fixed-delay pipeline, with early stall and sticky overflow
//   clk/reset              clock, synchronous active-high reset
//   in_valid/in_data       words from the upstream pipeline, no backpressure
//   stall_out              asks upstream to stop issuing (margin covers words in flight)
//   out_valid/out_ready    downstream handshake, out_data is the oldest word
//   count                  occupancy, overflow is sticky until reset
module delay_sink_fifo
    import delay_sink_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 5,
    localparam int AW          = clog2(DEPTH),
    localparam int CW          = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  stall_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, push;

    assign full      = count_q == CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    // a pop frees the head slot in the same edge, so a full buffer can still accept
    assign push      = in_valid & (~full | pop);
    assign stall_out = count_q >= CW'(DEPTH - STALL_MARGIN);
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        wptr_d     = reset ? '0 : wptr_q + AW'(push);
        rptr_d     = reset ? '0 : rptr_q + AW'(pop);
        count_d    = reset ? '0 : count_q + CW'(push) - CW'(pop);
        overflow_d = reset ? 1'b0 : overflow_q | (in_valid & ~push);
    end

    always_ff @(posedge clk) begin
        wptr_q     <= wptr_d;
        rptr_q     <= rptr_d;
        count_q    <= count_d;
        overflow_q <= overflow_d;
    end

    sink_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push & ~reset),
        .waddr(wptr_q),
        .wdata(in_data),
        .raddr(rptr_q),
        .rdata(out_data)
    );

endmodule

// File: tb/tb_delay_sink_fifo.sv
// tb_delay_sink_fifo: directed self-checking bench for delay_sink_fifo (DEPTH=16, STALL_MARGIN=5)
module tb_delay_sink_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        stall_out, out_valid, out_ready = 1'b0, overflow;
    logic [15:0] out_data;
    logic [4:0]  count;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] q[$];

    delay_sink_fifo #(.DATA_WIDTH(16), .DEPTH(16), .STALL_MARGIN(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .stall_out(stall_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vld"}, 32'(out_valid), 1);
            chk({tag, "_dat"}, 32'(out_data), 32'(q[0]));
            void'(q.pop_front());
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(out_valid), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        do_reset();
        chk("rst_cnt", 32'(count), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_stall", 32'(stall_out), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // stall threshold at 16-5 = 11 entries
        for (int i = 1; i <= 11; i++) begin
            push(16'(i));
            q.push_back(16'(i));
            chk("stall_ramp", 32'(stall_out), 32'(i >= 11));
        end
        chk("stall_cnt", 32'(count), 11);
        chk("stall_head", 32'(out_data), 16'h0001);

        for (int i = 12; i <= 16; i++) begin
            push(16'(i));
            q.push_back(16'(i));
        end
        chk("full_cnt", 32'(count), 16);
        chk("full_ovf0", 32'(overflow), 0);
        push(16'h0011);
        chk("ovf_cnt", 32'(count), 16);
        chk("ovf_flag", 32'(overflow), 1);
        drain("ovf_drain", 16);
        chk("ovf_sticky", 32'(overflow), 1);

        for (int i = 0; i < 7; i++) push(16'h0050 + 16'(i));
        chk("pre_rst_cnt", 32'(count), 7);
        do_reset();
        chk("rst2_cnt", 32'(count), 0);
        chk("rst2_vld", 32'(out_valid), 0);
        chk("rst2_stall", 32'(stall_out), 0);
        chk("rst2_ovf", 32'(overflow), 0);

        // full buffer: simultaneous push and pop must not drop
        for (int i = 1; i <= 16; i++) begin
            push(16'h0100 + 16'(i));
            q.push_back(16'h0100 + 16'(i));
        end
        in_valid = 1'b1;
        in_data  = 16'h0200;
        out_ready = 1'b1;
        chk("pp_head", 32'(out_data), 16'h0101);
        tick();
        void'(q.pop_front());
        q.push_back(16'h0200);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_cnt", 32'(count), 16);
        chk("pp_ovf", 32'(overflow), 0);
        drain("pp_drain", 16);

        // empty buffer: no fall-through path from in_data
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        out_ready = 1'b1;
        #1;
        chk("fwft_pre_vld", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("fwft_vld", 32'(out_valid), 1);
        chk("fwft_dat", 32'(out_data), 16'hABCD);
        chk("fwft_cnt", 32'(count), 1);
        q.push_back(16'hABCD);
        drain("fwft_drain", 1);

        // streaming with random out_ready across pointer wrap
        for (int i = 0; i < 40; i++) begin
            logic rdy, pop, full;
            rdy = $urandom_range(0, 3) != 0;
            in_valid = 1'b1;
            in_data  = 16'h3000 + 16'(i);
            out_ready = rdy;
            #1;
            full = q.size() == 16;
            pop = rdy && q.size() != 0;
            if (pop) begin
                chk("strm_dat", 32'(out_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (!full || pop) q.push_back(in_data);
            tick();
            chk("strm_cnt", 32'(count), 32'(q.size()));
        end
        in_valid = 1'b0;
        drain("strm_drain", q.size());
        chk("strm_ovf", 32'(overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
